// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero entry, write-to-read bypass,
// per-entry pending-write scoreboard and a sequential scrub engine.
module regfile_mp #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned RD_PORTS = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_ena,
   input  logic [AW-1:0]                wr_addr,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic [RD_PORTS*AW-1:0]       rd_addr,
   output logic [RD_PORTS*WIDTH-1:0]    rd_data,
   output logic [RD_PORTS-1:0]          rd_busy,
   input  logic                         rsv_ena,
   input  logic [AW-1:0]                rsv_addr,
   input  logic                         clr_req,
   output logic                         clr_busy,
   output logic                         clr_done
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [AW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;

   logic             w_idle;
   logic             w_last;
   logic             w_wr_acc;
   logic             w_rsv_acc;
   logic [AW-1:0]    w_ra  [RD_PORTS];
   logic [RD_PORTS-1:0] w_hit;

   function automatic logic f_valid(input logic [AW-1:0] a);
      return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
   endfunction

   assign w_idle    = (r_state == S_IDLE);
   assign w_last    = (r_cnt == AW'(DEPTH - 1));
   assign w_wr_acc  = wr_ena  && w_idle && f_valid(wr_addr);
   assign w_rsv_acc = rsv_ena && w_idle && f_valid(rsv_addr);
   assign clr_busy  = !w_idle;
   assign clr_done  = (r_state == S_DONE);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (clr_req) w_next = S_CLEAR;
         S_CLEAR: if (w_last)  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE)
            r_cnt <= '0;
         else if ((r_state == S_CLEAR) && !w_last)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < DEPTH; k++)
            r_mem[k] <= '0;
      end else if (r_state == S_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Reservation is applied after the write clear so it wins on a same-entry collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
      end else if (r_state == S_CLEAR) begin
         r_pend[r_cnt] <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_pend[wr_addr] <= 1'b0;
         if (w_rsv_acc)
            r_pend[rsv_addr] <= 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      w_hit   = '0;
      for (int unsigned i = 0; i < RD_PORTS; i++) begin
         w_ra[i]  = rd_addr[i*AW +: AW];
         w_hit[i] = BYPASS && w_wr_acc && (wr_addr == w_ra[i]);
         if (w_hit[i])
            rd_data[i*WIDTH +: WIDTH] = wr_data;
         else if (f_valid(w_ra[i]))
            rd_data[i*WIDTH +: WIDTH] = r_mem[w_ra[i]];
         rd_busy[i] = f_valid(w_ra[i]) && r_pend[w_ra[i]] && !w_hit[i];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and DEPTH=20 instances
// share one stimulus stream.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        wr_ena;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [9:0]  rd_addr;
   logic        rsv_ena;
   logic [4:0]  rsv_addr;
   logic        clr_req;

   logic [63:0] a_rd_data, b_rd_data, c_rd_data;
   logic [1:0]  a_rd_busy, b_rd_busy, c_rd_busy;
   logic        a_clr_busy, b_clr_busy, c_clr_busy;
   logic        a_clr_done, b_clr_done, c_clr_done;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp u_dut (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .rsv_ena(rsv_ena), .rsv_addr(rsv_addr), .clr_req(clr_req),
      .clr_busy(a_clr_busy), .clr_done(a_clr_done)
   );

   regfile_mp #(.BYPASS(1'b0)) u_nb (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .rsv_ena(rsv_ena), .rsv_addr(rsv_addr), .clr_req(clr_req),
      .clr_busy(b_clr_busy), .clr_done(b_clr_done)
   );

   regfile_mp #(.DEPTH(20)) u_d20 (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
      .rsv_ena(rsv_ena), .rsv_addr(rsv_addr), .clr_req(clr_req),
      .clr_busy(c_clr_busy), .clr_done(c_clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
      rd_addr = {p1, p0};
   endtask

   task automatic test_reset();
      set_rd(5'd5, 5'd1);
      #1;
      n_tests++; if (a_rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", a_rd_data); end
      n_tests++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b want 00", a_rd_busy); end
      n_tests++; if (a_clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b want 0", a_clr_busy); end
      n_tests++; if (a_clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done: got %b want 0", a_clr_done); end
   endtask

   task automatic test_write_read();
      wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      tick();
      wr_ena = 1'b0;
      set_rd(5'd5, 5'd5);
      #1;
      n_tests++; if (a_rd_data !== {2{32'hDEADBEEF}}) begin n_fail++; $display("FAIL wr_rd_both_ports: got %h want %h", a_rd_data, {2{32'hDEADBEEF}}); end
      n_tests++; if (b_rd_data !== {2{32'hDEADBEEF}}) begin n_fail++; $display("FAIL wr_rd_nobypass: got %h want %h", b_rd_data, {2{32'hDEADBEEF}}); end
      wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      set_rd(5'd0, 5'd5);
      #1;
      n_tests++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_reg_bypass: got %h want 0", a_rd_data[31:0]); end
      tick();
      wr_ena = 1'b0;
      #1;
      n_tests++; if (a_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_reg_write: got %h want 0", a_rd_data[31:0]); end
   endtask

   task automatic test_bypass();
      set_rd(5'd7, 5'd5);
      wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
      #1;
      n_tests++; if (a_rd_data[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_hit: got %h want a5a5a5a5", a_rd_data[31:0]); end
      n_tests++; if (b_rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_old: got %h want 0", b_rd_data[31:0]); end
      n_tests++; if (a_rd_data[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_other_port: got %h want deadbeef", a_rd_data[63:32]); end
      tick();
      wr_ena = 1'b0;
      #1;
      n_tests++; if (b_rd_data[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL nobypass_after_edge: got %h want a5a5a5a5", b_rd_data[31:0]); end
   endtask

   task automatic test_scoreboard();
      rsv_ena = 1'b1; rsv_addr = 5'd9;
      tick();
      rsv_ena = 1'b0;
      set_rd(5'd9, 5'd9);
      #1;
      n_tests++; if (a_rd_busy !== 2'b11) begin n_fail++; $display("FAIL rsv_busy: got %b want 11", a_rd_busy); end
      wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      #1;
      n_tests++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL busy_bypass_cycle: got %b want 00", a_rd_busy); end
      n_tests++; if (a_rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL data_bypass_cycle: got %h want 55", a_rd_data[31:0]); end
      n_tests++; if (b_rd_busy !== 2'b11) begin n_fail++; $display("FAIL nobypass_busy_cycle: got %b want 11", b_rd_busy); end
      tick();
      wr_ena = 1'b0;
      #1;
      n_tests++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL busy_after_write: got %b want 00", a_rd_busy); end
      n_tests++; if (b_rd_busy !== 2'b00) begin n_fail++; $display("FAIL nobypass_busy_after: got %b want 00", b_rd_busy); end
      rsv_ena = 1'b1; rsv_addr = 5'd9;
      wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      tick();
      rsv_ena = 1'b0; wr_ena = 1'b0;
      #1;
      n_tests++; if (a_rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL collide_data: got %h want 55", a_rd_data[31:0]); end
      n_tests++; if (a_rd_busy !== 2'b11) begin n_fail++; $display("FAIL collide_busy: got %b want 11", a_rd_busy); end
   endtask

   task automatic test_depth20();
      set_rd(5'd25, 5'd25);
      wr_ena = 1'b1; wr_addr = 5'd25; wr_data = 32'hFFFFFFFF;
      rsv_ena = 1'b1; rsv_addr = 5'd25;
      #1;
      n_tests++; if (c_rd_data !== 64'h0) begin n_fail++; $display("FAIL d20_no_bypass_oob: got %h want 0", c_rd_data); end
      tick();
      wr_ena = 1'b0; rsv_ena = 1'b0;
      #1;
      n_tests++; if (c_rd_data !== 64'h0) begin n_fail++; $display("FAIL d20_read_oob: got %h want 0", c_rd_data); end
      n_tests++; if (c_rd_busy !== 2'b00) begin n_fail++; $display("FAIL d20_busy_oob: got %b want 00", c_rd_busy); end
      n_tests++; if (a_rd_data[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL d32_addr25: got %h want ffffffff", a_rd_data[31:0]); end
      set_rd(5'd5, 5'd9);
      #1;
      n_tests++; if (c_rd_data !== {32'h55, 32'hDEADBEEF}) begin n_fail++; $display("FAIL d20_entries_kept: got %h want %h", c_rd_data, {32'h55, 32'hDEADBEEF}); end
      n_tests++; if (c_rd_busy !== 2'b10) begin n_fail++; $display("FAIL d20_busy_kept: got %b want 10", c_rd_busy); end
      set_rd(5'd19, 5'd20);
      #1;
      n_tests++; if (c_rd_data !== 64'h0) begin n_fail++; $display("FAIL d20_edge_addrs: got %h want 0", c_rd_data); end
   endtask

   task automatic test_scrub();
      int busy_cnt;
      int done_cnt;
      int done_at;
      for (int i = 1; i < 32; i++) begin
         wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
         tick();
      end
      wr_ena = 1'b0;
      rsv_ena = 1'b1; rsv_addr = 5'd3;
      tick();
      rsv_ena = 1'b0;
      set_rd(5'd3, 5'd31);
      #1;
      n_tests++; if (a_rd_data !== {32'd31, 32'd3}) begin n_fail++; $display("FAIL fill_data: got %h want %h", a_rd_data, {32'd31, 32'd3}); end
      n_tests++; if (a_rd_busy !== 2'b01) begin n_fail++; $display("FAIL fill_busy: got %b want 01", a_rd_busy); end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      set_rd(5'd4, 5'd20);
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      while (a_clr_busy && busy_cnt < 100) begin
         busy_cnt++;
         if (a_clr_done) begin done_cnt++; done_at = busy_cnt; end
         if (busy_cnt == 10) begin
            wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
            #1;
            n_tests++; if (a_rd_data !== {32'd20, 32'd0}) begin n_fail++; $display("FAIL scrub_partial: got %h want %h", a_rd_data, {32'd20, 32'd0}); end
         end
         if (busy_cnt == 11) wr_ena = 1'b0;
         tick();
      end
      wr_ena = 1'b0;
      n_tests++; if (busy_cnt != 33) begin n_fail++; $display("FAIL scrub_busy_cycles: got %0d want 33", busy_cnt); end
      n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL scrub_done_pulses: got %0d want 1", done_cnt); end
      n_tests++; if (done_at != 33) begin n_fail++; $display("FAIL scrub_done_cycle: got %0d want 33", done_at); end
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(a));
         #1;
         n_tests++;
         if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL scrub_clear addr %0d: got data %h busy %b want 0/00", a, a_rd_data, a_rd_busy);
         end
      end
   endtask

   task automatic test_reset_midscrub();
      int done_seen;
      wr_ena = 1'b1; wr_addr = 5'd20; wr_data = 32'hABCD;
      rsv_ena = 1'b1; rsv_addr = 5'd21;
      tick();
      wr_ena = 1'b0; rsv_ena = 1'b0;
      set_rd(5'd20, 5'd21);
      #1;
      n_tests++; if (a_rd_data[31:0] !== 32'hABCD || a_rd_busy !== 2'b10) begin n_fail++; $display("FAIL pre_scrub: got %h busy %b want abcd/10", a_rd_data[31:0], a_rd_busy); end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (10) tick();
      n_tests++; if (a_clr_busy !== 1'b1) begin n_fail++; $display("FAIL midscrub_busy: got %b want 1", a_clr_busy); end
      #2;
      rst = 1'b0;
      #1;
      n_tests++; if (a_clr_busy !== 1'b0) begin n_fail++; $display("FAIL abort_clr_busy: got %b want 0", a_clr_busy); end
      n_tests++; if (a_rd_data !== 64'h0) begin n_fail++; $display("FAIL abort_rd_data: got %h want 0", a_rd_data); end
      n_tests++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL abort_rd_busy: got %b want 00", a_rd_busy); end
      done_seen = 0;
      repeat (2) begin
         tick();
         if (a_clr_done) done_seen++;
      end
      rst = 1'b1;
      repeat (40) begin
         tick();
         if (a_clr_done || a_clr_busy) done_seen++;
      end
      n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d activity cycles want 0", done_seen); end
      wr_ena = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
      tick();
      wr_ena = 1'b0;
      set_rd(5'd2, 5'd2);
      #1;
      n_tests++; if (a_rd_data !== {2{32'h77}}) begin n_fail++; $display("FAIL post_reset_write: got %h want %h", a_rd_data, {2{32'h77}}); end
   endtask

   initial begin
      rst = 1'b0;
      wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0;
      rsv_ena = 1'b0; rsv_addr = '0;
      clr_req = 1'b0;
      test_reset();
      tick();
      tick();
      rst = 1'b1;
      tick();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_depth20();
      test_scrub();
      test_reset_midscrub();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the next RV32I core generation. Configurable width, depth and number of combinational read ports, with an optional hardwired-zero entry 0 and optional write-to-read bypass. Adds a per-entry pending-write scoreboard for multi-cycle producers, such as loads, and a sequential scrub engine that zeroes every entry on request. Sits between the decode stage (read ports) and the writeback stage (write port).

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries; need not be a power of two
RD_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
AW, $clog2(DEPTH), derived address width; not to be overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-low
wr_ena  in  1  write strobe
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rd_addr  in  RD_PORTS*AW  packed read addresses; port i uses slice [i*AW +: AW]
rd_data  out  RD_PORTS*WIDTH  packed read data; port i uses slice [i*WIDTH +: WIDTH]
rd_busy  out  RD_PORTS  port i's entry has an outstanding reservation
rsv_ena  in  1  reserve strobe; marks an entry pending
rsv_addr  in  AW  entry to reserve
clr_req  in  1  start a scrub of all entries
clr_busy  out  1  scrub in progress
clr_done  out  1  one-cycle pulse when the scrub completes

Behaviour:
- Reset (rst=0, asynchronous): all entries 0, all pending bits 0, FSM in IDLE, scrub counter 0, clr_busy=0, clr_done=0.
- An address is valid when addr < DEPTH and not (ZERO_REG and addr==0). Invalid addresses are ignored for writes and reservations.
- Write: when wr_ena=1, the FSM is IDLE and wr_addr is valid, the entry takes wr_data at the clock edge.
- Read: combinational with zero latency. rd_data_i is the entry at rd_addr_i. It returns 0 if rd_addr_i >= DEPTH, or if ZERO_REG and rd_addr_i==0.
- Bypass (BYPASS=1): if a write is accepted this cycle and wr_addr==rd_addr_i, rd_data_i = wr_data in the same cycle. With BYPASS=0, the old value is read until the edge.
- Scoreboard:
  - An accepted write to entry a clears pending[a].
  - rsv_ena with a valid rsv_addr, while the FSM is IDLE, sets pending[rsv_addr].
  - If a write and a reservation target the same entry in the same cycle, the reservation wins: pending ends at 1 and the data is written.
  - rd_busy_i = pending[rd_addr_i], forced 0 when a bypass hit serves port i, and 0 for invalid addresses.
- Scrub FSM with states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req=1. The counter is loaded with 0.
  - CLEAR: each cycle, entry[counter] <- 0 and pending[counter] <- 0, then the counter increments. Entry 0 is skipped harmlessly when ZERO_REG=1.
  - CLEAR -> DONE in the cycle the counter reaches DEPTH-1, after that entry is cleared. The scrub therefore takes exactly DEPTH cycles in CLEAR.
  - DONE: clr_done=1 for one cycle, then the FSM returns to IDLE.
  - clr_busy=1 in CLEAR and in DONE.
  - While not IDLE, writes and reservations are dropped. They are not queued, and they do not clear pending bits.
  - clr_req is ignored while not IDLE.
  - Reads remain live during a scrub and show partially cleared contents. Bypass is inactive, because no write is accepted.
- Reset asserted mid-scrub aborts immediately to the full reset state. No clr_done pulse is produced.

Test Plan:
- Reset, then write 0xDEADBEEF to entry 5; read port 0 addr 5 and port 1 addr 5 next cycle -> both 0xDEADBEEF. Write 0x1234 to addr 0 -> port 0 addr 0 reads 0.
- BYPASS=1: wr_ena=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr0=7 in the same cycle -> rd_data0=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 -> old value (0) until the edge.
- Scoreboard sequence:
  - Reserve entry 9 -> rd_busy for addr 9 = 1 next cycle.
  - Write entry 9 = 0x55 -> rd_busy=0 during the bypass cycle and after the edge.
  - Same-cycle reserve and write to entry 9 -> data=0x55, rd_busy stays 1.
- DEPTH=20 (non-power-of-2):
  - Write addr 25 -> no entry changes.
  - Read addr 25 -> 0.
  - Reserve addr 25 -> no rd_busy anywhere.
- Scrub:
  - Fill entries 1..31 with their index and reserve entry 3.
  - Pulse clr_req -> clr_busy=1 for 33 cycles and clr_done pulses once on cycle 33.
  - Afterwards all reads = 0 and rd_busy=0.
  - A write to addr 4 issued mid-scrub is dropped (reads 0 afterwards).
- Start a scrub, let 10 entries clear, assert rst=0 asynchronously mid-cycle -> outputs clear immediately, no clr_done. Released from reset, the block accepts a write to addr 2 = 0x77 normally.
